// File: rtl/obf_seq_pkg.sv
// Shared constants and state encoding for the obfuscation LUT sequencer.
package obf_seq_pkg;

  localparam int OBF_IGU_WIDTH     = 8;
  localparam int OBF_PPC_WIDTH     = 7;
  localparam int OBF_LUT_OUT_WIDTH = 16;

  localparam logic [OBF_LUT_OUT_WIDTH-1:0] OBF_LUT_END = 16'h0000;

  typedef enum logic {
    OBF_SEQ_IDLE = 1'b0,
    OBF_SEQ_SEQ  = 1'b1
  } obf_seq_state_e;

endpackage

// File: rtl/obf_seq_oreg.sv
// Valid/ready output register toward decode: loads when empty or accepted, flush clears valid.
module obf_seq_oreg (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_ready,
  input  logic        i_set,
  input  logic [31:0] i_insn,
  input  logic        i_subst,
  output logic        o_load,
  output logic        o_valid,
  output logic [31:0] o_insn,
  output logic        o_subst
);

  logic        r_valid;
  logic [31:0] r_insn;
  logic        r_subst;

  assign o_load  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_insn  = r_insn;
  assign o_subst = r_subst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_insn  <= '0;
      r_subst <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_load) begin
      r_valid <= i_set;
      if (i_set) begin
        r_insn  <= i_insn;
        r_subst <= i_subst;
      end
    end
  end

endmodule

// File: rtl/obf_seq.sv
// Sequencer that walks the substitution LUT for flagged fetches and passes others through.
// Optional overrun limit enabled with macro OBF_SEQ_LIMIT_EN.
module obf_seq
  import obf_seq_pkg::*;
#(
  parameter int MAX_STEPS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         if_valid,
  input  logic [31:0]                  if_insn,
  input  logic                         if_hit,
  input  logic [OBF_IGU_WIDTH-1:0]     if_index,
  output logic                         if_stall,
  output logic [OBF_IGU_WIDTH-1:0]     lut_index,
  output logic [OBF_PPC_WIDTH-1:0]     lut_ppc,
  input  logic [OBF_LUT_OUT_WIDTH-1:0] lut_sub,
  input  logic [OBF_LUT_OUT_WIDTH-1:0] lut_imm,
  output logic                         id_valid,
  output logic [31:0]                  id_insn,
  output logic                         id_subst,
  input  logic                         id_ready,
  output logic                         seq_err
);

  obf_seq_state_e             r_state, w_state_nxt;
  logic [OBF_IGU_WIDTH-1:0]   r_index, w_index_nxt;
  logic [OBF_PPC_WIDTH-1:0]   r_ppc, w_ppc_nxt;
  logic                       w_load;
  logic                       w_set;
  logic [31:0]                w_insn;
  logic                       w_subst;

`ifdef OBF_SEQ_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
`endif

  obf_seq_oreg u_oreg (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_ready (id_ready),
    .i_set   (w_set),
    .i_insn  (w_insn),
    .i_subst (w_subst),
    .o_load  (w_load),
    .o_valid (id_valid),
    .o_insn  (id_insn),
    .o_subst (id_subst)
  );

  assign lut_index = r_index;
  assign lut_ppc   = r_ppc;
  assign if_stall  = (r_state == OBF_SEQ_SEQ) || (id_valid && !id_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OBF_SEQ_IDLE;
      r_index <= '0;
      r_ppc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_ppc   <= w_ppc_nxt;
    end
  end

`ifdef OBF_SEQ_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end
  assign seq_err = r_err;
`else
  assign seq_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_ppc_nxt   = r_ppc;
    w_set       = 1'b0;
    w_insn      = if_insn;
    w_subst     = 1'b0;
`ifdef OBF_SEQ_LIMIT_EN
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
`endif
    if (flush) begin
      w_state_nxt = OBF_SEQ_IDLE;
      w_ppc_nxt   = '0;
`ifdef OBF_SEQ_LIMIT_EN
      w_cnt_nxt   = '0;
`endif
    end else if (w_load) begin
      case (r_state)
        OBF_SEQ_IDLE: begin
          if (if_valid && !if_hit) begin
            w_set = 1'b1;
          end else if (if_valid && if_hit) begin
            w_index_nxt = if_index;
            w_ppc_nxt   = '0;
            w_state_nxt = OBF_SEQ_SEQ;
`ifdef OBF_SEQ_LIMIT_EN
            w_cnt_nxt   = '0;
`endif
          end
        end
        OBF_SEQ_SEQ: begin
          if (lut_sub == OBF_LUT_END) begin
            w_ppc_nxt   = '0;
            w_state_nxt = OBF_SEQ_IDLE;
`ifdef OBF_SEQ_LIMIT_EN
          end else if (r_cnt == CNT_W'(MAX_STEPS)) begin
            // Overrun: drop the word and abandon the sequence
            w_ppc_nxt   = '0;
            w_state_nxt = OBF_SEQ_IDLE;
            w_err_nxt   = 1'b1;
`endif
          end else begin
            w_set     = 1'b1;
            w_insn    = {lut_sub, lut_imm};
            w_subst   = 1'b1;
            w_ppc_nxt = r_ppc + OBF_PPC_WIDTH'(2);
`ifdef OBF_SEQ_LIMIT_EN
            w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
          end
        end
        default: w_state_nxt = OBF_SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obf_seq.sv
// Directed bench for obf_seq with a small combinational LUT model.
module tb_obf_seq;
  import obf_seq_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         flush;
  logic                         if_valid;
  logic [31:0]                  if_insn;
  logic                         if_hit;
  logic [OBF_IGU_WIDTH-1:0]     if_index;
  logic                         if_stall;
  logic [OBF_IGU_WIDTH-1:0]     lut_index;
  logic [OBF_PPC_WIDTH-1:0]     lut_ppc;
  logic [OBF_LUT_OUT_WIDTH-1:0] lut_sub;
  logic [OBF_LUT_OUT_WIDTH-1:0] lut_imm;
  logic                         id_valid;
  logic [31:0]                  id_insn;
  logic                         id_subst;
  logic                         id_ready;
  logic                         seq_err;

  int ntests = 0;
  int nfail  = 0;
  int lut_mode;
  logic lut_stop;
  int nsteps;

  obf_seq #(.MAX_STEPS(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_insn(if_insn), .if_hit(if_hit), .if_index(if_index),
    .if_stall(if_stall), .lut_index(lut_index), .lut_ppc(lut_ppc),
    .lut_sub(lut_sub), .lut_imm(lut_imm),
    .id_valid(id_valid), .id_insn(id_insn), .id_subst(id_subst),
    .id_ready(id_ready), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // LUT model: mode 0 ends at ppc 6, mode 2 ends only when lut_stop is raised
  always_comb begin
    lut_sub = 16'h1100 | 16'(lut_ppc);
    lut_imm = 16'h2200 | 16'(lut_index);
    if (lut_mode == 0 && lut_ppc >= 7'd6) lut_sub = 16'h0000;
    if (lut_mode == 2 && lut_stop)        lut_sub = 16'h0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_insn = '0; if_hit = 1'b0;
    if_index = '0; id_ready = 1'b1; lut_mode = 0; lut_stop = 1'b0;
    tick(); tick();
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_insn", 64'(id_insn), 64'd0);
    chk("rst_id_subst", 64'(id_subst), 64'd0);
    chk("rst_lut_index", 64'(lut_index), 64'd0);
    chk("rst_lut_ppc", 64'(lut_ppc), 64'd0);
    chk("rst_seq_err", 64'(seq_err), 64'd0);
    chk("rst_if_stall", 64'(if_stall), 64'd0);
    rst = 1'b0;
    tick();

    // Pass-through
    if_valid = 1'b1; if_insn = 32'h15000000; if_hit = 1'b0;
    tick();
    if_valid = 1'b0;
    chk("pt_valid", 64'(id_valid), 64'd1);
    chk("pt_insn", 64'(id_insn), 64'h15000000);
    chk("pt_subst", 64'(id_subst), 64'd0);
    chk("pt_stall", 64'(if_stall), 64'd0);

    // Substitution with end marker at ppc 6
    if_valid = 1'b1; if_hit = 1'b1; if_index = 8'd27;
    tick();
    if_valid = 1'b0; if_hit = 1'b0;
    chk("sq_accept_valid", 64'(id_valid), 64'd0);
    chk("sq_index", 64'(lut_index), 64'd27);
    chk("sq_ppc0", 64'(lut_ppc), 64'd0);
    chk("sq_stall0", 64'(if_stall), 64'd1);
    tick();
    chk("sq_s0_insn", 64'(id_insn), 64'h1100221B);
    chk("sq_s0_subst", 64'(id_subst), 64'd1);
    chk("sq_ppc2", 64'(lut_ppc), 64'd2);
    chk("sq_stall1", 64'(if_stall), 64'd1);
    tick();
    chk("sq_s1_insn", 64'(id_insn), 64'h1102221B);
    chk("sq_ppc4", 64'(lut_ppc), 64'd4);
    chk("sq_stall2", 64'(if_stall), 64'd1);
    tick();
    chk("sq_s2_insn", 64'(id_insn), 64'h1104221B);
    chk("sq_s2_valid", 64'(id_valid), 64'd1);
    chk("sq_ppc6", 64'(lut_ppc), 64'd6);
    chk("sq_stall3", 64'(if_stall), 64'd1);
    tick();
    chk("sq_bubble_valid", 64'(id_valid), 64'd0);
    chk("sq_bubble_stall", 64'(if_stall), 64'd0);
    chk("sq_end_ppc", 64'(lut_ppc), 64'd0);

    // Backpressure on the second step
    if_valid = 1'b1; if_hit = 1'b1; if_index = 8'd27;
    tick();
    if_valid = 1'b0; if_hit = 1'b0;
    tick();
    tick();
    chk("bp_s1_insn", 64'(id_insn), 64'h1102221B);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_insn", 64'(id_insn), 64'h1102221B);
      chk("bp_hold_ppc", 64'(lut_ppc), 64'd4);
      chk("bp_hold_valid", 64'(id_valid), 64'd1);
      chk("bp_hold_stall", 64'(if_stall), 64'd1);
    end
    id_ready = 1'b1;
    tick();
    chk("bp_s2_insn", 64'(id_insn), 64'h1104221B);
    chk("bp_s2_ppc", 64'(lut_ppc), 64'd6);
    tick();
    chk("bp_end_valid", 64'(id_valid), 64'd0);
    chk("bp_end_stall", 64'(if_stall), 64'd0);

    // Flush while step 1 is presented, with a competing fetch
    if_valid = 1'b1; if_hit = 1'b1; if_index = 8'd27;
    tick();
    if_hit = 1'b0; if_valid = 1'b0;
    tick();
    chk("fl_s0_insn", 64'(id_insn), 64'h1100221B);
    flush = 1'b1; if_valid = 1'b1; if_insn = 32'hDEADBEEF;
    tick();
    flush = 1'b0; if_insn = 32'h00000013;
    chk("fl_valid", 64'(id_valid), 64'd0);
    chk("fl_stall", 64'(if_stall), 64'd0);
    chk("fl_ppc", 64'(lut_ppc), 64'd0);
    tick();
    if_valid = 1'b0;
    chk("fl_next_valid", 64'(id_valid), 64'd1);
    chk("fl_next_insn", 64'(id_insn), 64'h00000013);
    tick();
    chk("fl_idle_valid", 64'(id_valid), 64'd0);

`ifdef OBF_SEQ_LIMIT_EN
    // Overrun limit with MAX_STEPS = 4 and no end marker
    lut_mode = 2; lut_stop = 1'b0; nsteps = 0;
    if_valid = 1'b1; if_hit = 1'b1; if_index = 8'd27;
    tick();
    if_valid = 1'b0; if_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (id_valid) nsteps++;
    end
    chk("lim_steps", 64'(nsteps), 64'd4);
    chk("lim_err", 64'(seq_err), 64'd1);
    chk("lim_stall", 64'(if_stall), 64'd0);
    chk("lim_ppc", 64'(lut_ppc), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("lim_err_after_flush", 64'(seq_err), 64'd1);
`else
    // 70-step sequence wrapping the 7-bit ppc
    lut_mode = 2; lut_stop = 1'b0; nsteps = 0;
    if_valid = 1'b1; if_hit = 1'b1; if_index = 8'd27;
    tick();
    if_valid = 1'b0; if_hit = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (id_valid) nsteps++;
      if (k == 62) chk("wr_ppc126", 64'(lut_ppc), 64'd126);
      if (k == 63) begin
        chk("wr_ppc0", 64'(lut_ppc), 64'd0);
        chk("wr_s63_insn", 64'(id_insn), 64'h117E221B);
      end
    end
    chk("wr_steps", 64'(nsteps), 64'd70);
    chk("wr_ppc_final", 64'(lut_ppc), 64'd12);
    chk("wr_stall", 64'(if_stall), 64'd1);
    lut_stop = 1'b1;
    tick();
    chk("wr_end_valid", 64'(id_valid), 64'd0);
    chk("wr_end_stall", 64'(if_stall), 64'd0);
    chk("wr_err", 64'(seq_err), 64'd0);
`endif

    // Reset asserted mid-sequence
    lut_mode = 2; lut_stop = 1'b0;
    if_valid = 1'b1; if_hit = 1'b1; if_index = 8'd5;
    tick();
    if_valid = 1'b0; if_hit = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(id_valid), 64'd0);
    chk("mid_rst_stall", 64'(if_stall), 64'd0);
    chk("mid_rst_index", 64'(lut_index), 64'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/obf_seq.md
# obf_seq

Sequencer for the obfuscation substitution LUT. It sits between instruction fetch and decode and drives the LUT `index`/`ppc` address inputs. For a fetched instruction flagged for substitution, it stalls fetch and steps `ppc` through the LUT sequence, emitting one `{sub, imm}` instruction per step to decode. Unflagged instructions pass through unchanged.

## Interface
- `MAX_STEPS`, default 16: maximum substitution steps per sequence. Used only with `OBF_SEQ_LIMIT_EN`.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  branch/exception flush; synchronous.
- `if_valid`  in  1  fetched instruction present.
- `if_insn`  in  32  fetched instruction.
- `if_hit`  in  1  IGU marks the instruction for substitution.
- `if_index`  in  `OBF_IGU_WIDTH`  IGU index of the instruction.
- `if_stall`  out  1  holds fetch.
- `lut_index`  out  `OBF_IGU_WIDTH`  to LUT `index`.
- `lut_ppc`  out  `OBF_PPC_WIDTH`  to LUT `ppc`.
- `lut_sub`  in  16  LUT `out_sub`.
- `lut_imm`  in  16  LUT `out_imm`.
- `id_valid`  out  1  instruction presented to decode.
- `id_insn`  out  32  instruction presented to decode.
- `id_subst`  out  1  `id_insn` originates from the LUT.
- `id_ready`  in  1  decode accepts `id_insn` this cycle.
- `seq_err`  out  1  sticky sequence-overrun flag.

## Operation
- States:
  - IDLE (pass-through).
  - SEQ (walking the LUT).
- The output register (`id_valid`, `id_insn`, `id_subst`) may load only when `!id_valid || id_ready`; this condition is called "load".
- In IDLE, on load with `if_valid`:
  - `!if_hit`: `id_insn <= if_insn`, `id_subst <= 0`, `id_valid <= 1`.
  - `if_hit`: latch `lut_index <= if_index`, `lut_ppc <= 0`, go to SEQ. `id_valid` clears if the current output was accepted.
- In IDLE, load without `if_valid`: `id_valid <= 0`.
- In SEQ, on load:
  - If `lut_sub == OBF_LUT_END` (16'h0000): emit nothing (`id_valid <= 0`), `lut_ppc <= 0`, go to IDLE.
  - Otherwise: `id_insn <= {lut_sub, lut_imm}`, `id_subst <= 1`, `id_valid <= 1`, `lut_ppc <= lut_ppc + 2`.
- In SEQ without load, all state is held.
- `lut_ppc` arithmetic is unsigned, `OBF_PPC_WIDTH` bits, and wraps modulo 2^width.
- `if_stall = (state == SEQ) || (id_valid && !id_ready)`. It is combinational.
- `flush`:
  - Next edge: IDLE, `id_valid <= 0`, `lut_ppc <= 0`.
  - `flush` with `if_valid` in the same cycle: flush wins and the instruction is dropped.
  - `flush` has priority over every other transition.
- `key` is not handled by this block.

## Timing
- Reset values:
  - state IDLE.
  - `id_valid = 0`, `id_insn = 0`, `id_subst = 0`.
  - `lut_index = 0`, `lut_ppc = 0`.
  - `seq_err = 0`, `if_stall = 0`.
- Pass-through latency: 1 cycle from `if_valid` accept to `id_valid`.
- Substitution latency: the first step appears 2 cycles after accept. Each following step takes 1 cycle while `id_ready = 1`.
- The LUT is combinational: a `lut_ppc` registered at edge N yields `lut_sub` and `lut_imm` within the cycle following N.
- After the end marker, there is one bubble cycle. `if_stall` drops in the cycle after the marker is consumed, unless output backpressure holds it.
- A reset asserted mid-sequence returns the block to IDLE immediately; the partial sequence is discarded.

## Configuration
- `OBF_SEQ_LIMIT_EN` defined:
  - A step counter (width `$clog2(MAX_STEPS+1)`) counts steps emitted in SEQ.
  - If `MAX_STEPS` steps have been emitted and the next `lut_sub` is not `OBF_LUT_END`, the block goes to IDLE without emitting that word and sets `seq_err <= 1`.
  - `seq_err` stays set until `rst`; `flush` does not clear it.
- `OBF_SEQ_LIMIT_EN` undefined:
  - No counter.
  - `seq_err` is tied to 0.
  - Sequences run until the end marker, with `ppc` wrapping.

## Structure
- `obf_defines.v` (shared include) holds:
  - `OBF_LUT_END`.
  - The state encodings `OBF_SEQ_IDLE` and `OBF_SEQ_SEQ`.
  - The existing `OBF_IGU_WIDTH`, `OBF_PPC_WIDTH` and `OBF_LUT_OUT_WIDTH`.
- `obf_lut` is instantiated alongside this block by the parent, not inside it.
- One sub-module is natural: `obf_seq_oreg`, the valid/ready output register with load-enable and flush clear.

## Test plan
- Reset with `if_valid = 0`: all outputs 0. Release reset, then present `if_insn = 32'h15000000`, `if_hit = 0`: one cycle later `id_valid = 1`, `id_insn = 32'h15000000`, `id_subst = 0`.
- `if_hit = 1`, `if_index = 27`, LUT model with words at ppc 0/2/4 and `OBF_LUT_END` at ppc 6:
  - Three `id_insn` values equal to `{lut_sub, lut_imm}` at ppc 0, 2, 4.
  - `lut_ppc` sequence 0, 2, 4, 6.
  - `if_stall = 1` for 4 cycles, followed by 1 bubble.
- Hold `id_ready = 0` for 3 cycles during step 2: `id_insn` is stable, `lut_ppc` is held at 4, and no step is lost or duplicated.
- Assert `flush` in the cycle step 1 is emitted: the next cycle has `id_valid = 0` and state IDLE; a new `if_valid` is accepted 1 cycle later.
- With `OBF_SEQ_LIMIT_EN` and `MAX_STEPS = 4`, LUT with no end marker: exactly 4 steps are emitted, then `seq_err = 1`, state IDLE, and `seq_err` remains 1 after a `flush`.
- Without the macro and `OBF_PPC_WIDTH = 7`, a 70-step sequence: `lut_ppc` wraps 126 → 0 and no `seq_err` is raised.
